// File: rtl/stg_1_if_fetch_queue.sv
// Instruction-fetch stage 1: PC generation, in-order requests to a variable-latency
// instruction memory, a fetch queue towards ID, and branch redirect with squashing of
// responses that belong to the abandoned path.
module stg_1_if_fetch_queue #(
  parameter int unsigned INSTR_W         = 32,
  parameter int unsigned INSTR_ADDR_W    = 16,
  parameter int unsigned NUM_INSTRS      = 2 ** INSTR_ADDR_W,
  parameter int unsigned FQ_DEPTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [INSTR_ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [INSTR_ADDR_W-1:0] mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [INSTR_W-1:0]      mem_rsp_data,
  input  logic                    redirect_valid,
  input  logic [INSTR_ADDR_W-1:0] redirect_pc,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [INSTR_W-1:0]      id_instr,
  output logic [INSTR_ADDR_W-1:0] id_pc,
  output logic [9:0]              LEDR
);

  localparam int unsigned FqPtrW = $clog2(FQ_DEPTH);
  localparam int unsigned FqCntW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned IfPtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned IfCntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [INSTR_ADDR_W:0] NumInstrsExt = (INSTR_ADDR_W + 1)'(NUM_INSTRS);

  localparam logic [1:0] StBoot  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [INSTR_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [IfCntW-1:0]       stale_q, stale_d;

  // Fetch queue: returned words paired with their PC.
  logic [INSTR_W-1:0]      fq_instr_q [FQ_DEPTH];
  logic [INSTR_ADDR_W-1:0] fq_pc_q    [FQ_DEPTH];
  logic [FqPtrW-1:0]       fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
  logic [FqCntW-1:0]       fq_cnt_q, fq_cnt_d;

  // In-flight FIFO: addresses of accepted requests still awaiting data.
  logic [INSTR_ADDR_W-1:0] if_addr_q [MAX_OUTSTANDING];
  logic [IfPtrW-1:0]       if_rd_q, if_rd_d, if_wr_q, if_wr_d;
  logic [IfCntW-1:0]       if_cnt_q, if_cnt_d;

  logic                    req_acc, id_pop, rsp_live, rsp_stale, fq_push, if_push;
  logic [INSTR_ADDR_W-1:0] pc_next, redirect_tgt;

  // Request credit: never more outstanding reads than free queue slots.
  assign mem_req_valid = (state_q == StRun) &&
                         (32'(if_cnt_q) < MAX_OUTSTANDING) &&
                         (32'(if_cnt_q) + 32'(fq_cnt_q) < FQ_DEPTH);
  assign mem_req_addr  = fetch_pc_q;
  assign req_acc       = mem_req_valid && mem_req_ready;

  assign id_valid = (fq_cnt_q != '0);
  assign id_instr = id_valid ? fq_instr_q[fq_rd_q] : '0;
  assign id_pc    = id_valid ? fq_pc_q[fq_rd_q] : '0;
  assign id_pop   = id_valid && id_ready;

  // Responses are in order, so any pending stale ones arrive before live ones.
  assign rsp_stale = mem_rsp_valid && (stale_q != '0);
  assign rsp_live  = mem_rsp_valid && (stale_q == '0);
  assign fq_push   = rsp_live && !redirect_valid;
  assign if_push   = req_acc && !redirect_valid;

  assign pc_next      = (({1'b0, fetch_pc_q} + (INSTR_ADDR_W + 1)'(1)) == NumInstrsExt) ?
                        '0 : fetch_pc_q + INSTR_ADDR_W'(1);
  assign redirect_tgt = ({1'b0, redirect_pc} >= NumInstrsExt) ? '0 : redirect_pc;

  if (INSTR_ADDR_W >= 10) begin : g_led_trunc
    assign LEDR = fetch_pc_q[9:0];
  end else begin : g_led_ext
    assign LEDR = {{(10 - INSTR_ADDR_W){1'b0}}, fetch_pc_q};
  end

  // Next-state: FSM, PC, stale counter and both FIFO pointer sets.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    fq_rd_d    = fq_rd_q;
    fq_wr_d    = fq_wr_q;
    fq_cnt_d   = fq_cnt_q;
    if_rd_d    = if_rd_q;
    if_wr_d    = if_wr_q;
    if_cnt_d   = if_cnt_q;

    if (redirect_valid) begin
      // Everything outstanding (incl. this cycle's accept) turns stale; a response
      // arriving now is dropped and so no longer outstanding.
      fetch_pc_d = redirect_tgt;
      stale_d    = IfCntW'(32'(stale_q) + 32'(if_cnt_q) + 32'(req_acc) - 32'(mem_rsp_valid));
      fq_rd_d    = '0;
      fq_wr_d    = '0;
      fq_cnt_d   = '0;
      if_rd_d    = '0;
      if_wr_d    = '0;
      if_cnt_d   = '0;
    end else begin
      if (req_acc) fetch_pc_d = pc_next;
      if (rsp_stale) stale_d = stale_q - IfCntW'(1);
      if (fq_push) fq_wr_d = (fq_wr_q == FqPtrW'(FQ_DEPTH - 1)) ? '0 : fq_wr_q + FqPtrW'(1);
      if (id_pop)  fq_rd_d = (fq_rd_q == FqPtrW'(FQ_DEPTH - 1)) ? '0 : fq_rd_q + FqPtrW'(1);
      fq_cnt_d = fq_cnt_q + FqCntW'(fq_push) - FqCntW'(id_pop);
      if (if_push) begin
        if_wr_d = (if_wr_q == IfPtrW'(MAX_OUTSTANDING - 1)) ? '0 : if_wr_q + IfPtrW'(1);
      end
      if (rsp_live) begin
        if_rd_d = (if_rd_q == IfPtrW'(MAX_OUTSTANDING - 1)) ? '0 : if_rd_q + IfPtrW'(1);
      end
      if_cnt_d = if_cnt_q + IfCntW'(if_push) - IfCntW'(rsp_live);
    end

    case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (redirect_valid && (stale_d != '0)) state_d = StFlush;
      StFlush: if (stale_d == '0) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      stale_q    <= '0;
      fq_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_cnt_q   <= '0;
      if_rd_q    <= '0;
      if_wr_q    <= '0;
      if_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_q    <= stale_d;
      fq_rd_q    <= fq_rd_d;
      fq_wr_q    <= fq_wr_d;
      fq_cnt_q   <= fq_cnt_d;
      if_rd_q    <= if_rd_d;
      if_wr_q    <= if_wr_d;
      if_cnt_q   <= if_cnt_d;
    end
  end

  // FIFO storage; contents are only meaningful under the counters, so no reset.
  always_ff @(posedge clock) begin
    if (fq_push) begin
      fq_instr_q[fq_wr_q] <= mem_rsp_data;
      fq_pc_q[fq_wr_q]    <= if_addr_q[if_rd_q];
    end
    if (if_push) if_addr_q[if_wr_q] <= fetch_pc_q;
  end

endmodule

// File: tb/tb_stg_1_if_fetch_queue.sv
// Directed bench for stg_1_if_fetch_queue with a fixed-latency in-order memory model.
module tb_stg_1_if_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_req_ready;
  logic [15:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr;
  logic [15:0] id_pc;
  logic [9:0]  LEDR;

  int vectors = 0;
  int miscompares = 0;
  int mem_lat = 1;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;
  pend_t pend[$];

  // Values captured by step() just before the clock edge closing a cycle.
  logic        s_iv, s_hs, s_rv, s_acc;
  logic [15:0] s_pc, s_ra;
  logic [31:0] s_ins;
  logic [9:0]  s_led;

  stg_1_if_fetch_queue #(
    .INSTR_W        (32),
    .INSTR_ADDR_W   (16),
    .NUM_INSTRS     (128),
    .FQ_DEPTH       (4),
    .MAX_OUTSTANDING(2),
    .RESET_PC       (16'h0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .LEDR          (LEDR)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [15:0] a);
    return {a ^ 16'hBEEF, a};
  endfunction

  // Memory: a request accepted in cycle t answers in cycle t + mem_lat.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clock);
      cyc++;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = instr_of(pend[0].addr);
        void'(pend.pop_front());
      end
      #4;
      if (reset) pend.delete();
      else if (mem_req_valid && mem_req_ready) pend.push_back('{due: cyc + mem_lat, addr: mem_req_addr});
    end
  end

  task automatic step();
    #4;
    s_iv  = id_valid;
    s_hs  = id_valid && id_ready;
    s_pc  = id_pc;
    s_ins = id_instr;
    s_rv  = mem_req_valid;
    s_acc = mem_req_valid && mem_req_ready;
    s_ra  = mem_req_addr;
    s_led = LEDR;
    @(negedge clock);
  endtask

  // Leaves the bench at the start of the first post-reset cycle (BOOT).
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b1;
    id_ready       = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    vectors++; if (s_rv !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %0h want 0", s_rv); end
    vectors++; if (s_ra !== 16'h0) begin miscompares++; $display("FAIL reset_req_addr: got %0h want 0", s_ra); end
    vectors++; if (s_iv !== 1'b0) begin miscompares++; $display("FAIL reset_id_valid: got %0h want 0", s_iv); end
    vectors++; if (s_ins !== 32'h0) begin miscompares++; $display("FAIL reset_id_instr: got %0h want 0", s_ins); end
    vectors++; if (s_pc !== 16'h0) begin miscompares++; $display("FAIL reset_id_pc: got %0h want 0", s_pc); end
    vectors++; if (s_led !== 10'h0) begin miscompares++; $display("FAIL reset_ledr: got %0h want 0", s_led); end
  endtask

  task automatic test_throughput();
    logic [15:0] exp = 16'h0;
    int first = -1;
    int n = 0;
    mem_lat = 1;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      step();
      if (c == 1) begin
        vectors++; if (s_acc !== 1'b1 || s_ra !== 16'h0) begin miscompares++;
          $display("FAIL first_request: got acc=%0h addr=%0h want acc=1 addr=0", s_acc, s_ra); end
      end
      if (s_iv && first < 0) first = c;
      if (s_hs) begin
        vectors++; if (s_pc !== exp || s_ins !== instr_of(exp)) begin miscompares++;
          $display("FAIL thru_pc: got pc=%0h instr=%0h want pc=%0h instr=%0h", s_pc, s_ins, exp, instr_of(exp)); end
        exp++;
        n++;
      end
    end
    vectors++; if (first != 3) begin miscompares++; $display("FAIL first_id_valid_cycle: got %0d want 3", first); end
    vectors++; if (n != 8) begin miscompares++; $display("FAIL thru_count: got %0d want 8", n); end
  endtask

  task automatic test_backpressure();
    mem_lat = 1;
    do_reset();
    id_ready = 1'b0;
    for (int c = 0; c < 10; c++) step();
    vectors++; if (s_iv !== 1'b1 || s_pc !== 16'h0) begin miscompares++;
      $display("FAIL bp_head: got valid=%0h pc=%0h want valid=1 pc=0", s_iv, s_pc); end
    vectors++; if (s_rv !== 1'b0) begin miscompares++; $display("FAIL bp_req_blocked: got %0h want 0", s_rv); end
    id_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      vectors++; if (s_hs !== 1'b1 || s_pc !== 16'(c) || s_ins !== instr_of(16'(c))) begin miscompares++;
        $display("FAIL bp_drain: got hs=%0h pc=%0h want hs=1 pc=%0h", s_hs, s_pc, c); end
    end
  endtask

  task automatic test_mem_stall();
    logic [15:0] exp = 16'h0;
    int n = 0;
    mem_lat = 1;
    do_reset();
    mem_req_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c >= 1) begin
        vectors++; if (s_rv !== 1'b1 || s_ra !== 16'h0) begin miscompares++;
          $display("FAIL stall_addr: got valid=%0h addr=%0h want valid=1 addr=0", s_rv, s_ra); end
      end
    end
    vectors++; if (s_iv !== 1'b0) begin miscompares++; $display("FAIL stall_id_valid: got %0h want 0", s_iv); end
    mem_req_ready = 1'b1;
    for (int c = 0; c < 20 && n < 6; c++) begin
      step();
      if (s_hs) begin
        vectors++; if (s_pc !== exp || s_ins !== instr_of(exp)) begin miscompares++;
          $display("FAIL stall_seq: got pc=%0h want pc=%0h", s_pc, exp); end
        exp++;
        n++;
      end
    end
    vectors++; if (n != 6) begin miscompares++; $display("FAIL stall_count: got %0d want 6", n); end
  endtask

  task automatic test_redirect_flush();
    logic [15:0] exp = 16'h40;
    int n = 0;
    mem_lat = 3;
    do_reset();
    step();
    step();
    step();
    vectors++; if (s_acc !== 1'b1 || s_ra !== 16'h1) begin miscompares++;
      $display("FAIL rd_second_req: got acc=%0h addr=%0h want acc=1 addr=1", s_acc, s_ra); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h40;
    step();
    redirect_valid = 1'b0;
    vectors++; if (s_rv !== 1'b0) begin miscompares++; $display("FAIL rd_credit_full: got %0h want 0", s_rv); end
    step();
    vectors++; if (s_rv !== 1'b0 || s_iv !== 1'b0) begin miscompares++;
      $display("FAIL rd_flush1: got req=%0h idv=%0h want 0 0", s_rv, s_iv); end
    vectors++; if (s_led !== 10'h40) begin miscompares++; $display("FAIL rd_ledr: got %0h want 40", s_led); end
    step();
    vectors++; if (s_rv !== 1'b0) begin miscompares++; $display("FAIL rd_flush2: got %0h want 0", s_rv); end
    step();
    vectors++; if (s_rv !== 1'b1 || s_ra !== 16'h40) begin miscompares++;
      $display("FAIL rd_resume: got valid=%0h addr=%0h want valid=1 addr=40", s_rv, s_ra); end
    for (int c = 0; c < 20 && n < 3; c++) begin
      step();
      if (s_hs) begin
        vectors++; if (s_pc !== exp || s_ins !== instr_of(exp)) begin miscompares++;
          $display("FAIL rd_seq: got pc=%0h want pc=%0h", s_pc, exp); end
        exp++;
        n++;
      end
    end
    vectors++; if (n != 3) begin miscompares++; $display("FAIL rd_count: got %0d want 3", n); end
  endtask

  task automatic test_wrap_and_clamp();
    logic [15:0] exp = 16'h0;
    int n = 0;
    logic saw127 = 1'b0;
    mem_lat = 1;
    do_reset();
    for (int c = 0; c < 10 && n < 2; c++) begin
      step();
      if (s_hs) begin
        vectors++; if (s_pc !== exp) begin miscompares++; $display("FAIL wrap_pre: got %0h want %0h", s_pc, exp); end
        exp++;
        n++;
      end
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'd126;
    step();
    redirect_valid = 1'b0;
    if (s_hs) begin
      vectors++; if (s_pc !== exp) begin miscompares++; $display("FAIL wrap_redir_hs: got %0h want %0h", s_pc, exp); end
    end
    exp = 16'd126;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      if (c == 0) begin
        vectors++; if (s_led !== 10'd126) begin miscompares++; $display("FAIL wrap_ledr_tgt: got %0d want 126", s_led); end
      end
      if (saw127) begin
        vectors++; if (s_led !== 10'd0 || s_ra !== 16'd0) begin miscompares++;
          $display("FAIL wrap_pc_zero: got ledr=%0d addr=%0d want 0 0", s_led, s_ra); end
        saw127 = 1'b0;
      end
      if (s_acc && s_ra == 16'd127) saw127 = 1'b1;
      if (s_hs) begin
        vectors++; if (s_pc !== exp || s_ins !== instr_of(exp)) begin miscompares++;
          $display("FAIL wrap_seq: got pc=%0d want pc=%0d", s_pc, exp); end
        exp = (exp == 16'd127) ? 16'd0 : exp + 16'd1;
        n++;
      end
    end
    vectors++; if (n != 4) begin miscompares++; $display("FAIL wrap_count: got %0d want 4", n); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'd200;
    step();
    redirect_valid = 1'b0;
    if (s_hs) begin
      vectors++; if (s_pc !== exp) begin miscompares++; $display("FAIL clamp_redir_hs: got %0h want %0h", s_pc, exp); end
    end
    n = 0;
    for (int c = 0; c < 12 && n < 1; c++) begin
      step();
      if (s_hs) begin
        vectors++; if (s_pc !== 16'd0) begin miscompares++; $display("FAIL clamp_pc: got %0d want 0", s_pc); end
        n++;
      end
    end
    vectors++; if (n != 1) begin miscompares++; $display("FAIL clamp_count: got %0d want 1", n); end
  endtask

  task automatic test_reset_midop();
    int first = -1;
    int n = 0;
    mem_lat = 3;
    do_reset();
    id_ready = 1'b0;
    for (int c = 0; c < 8; c++) step();
    vectors++; if (s_iv !== 1'b1) begin miscompares++; $display("FAIL mid_prefill: got %0h want 1", s_iv); end
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h33;
    id_ready       = 1'b1;
    step();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    mem_lat        = 1;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) begin
        vectors++; if (s_iv !== 1'b0 || s_rv !== 1'b0) begin miscompares++;
          $display("FAIL mid_after_reset: got idv=%0h req=%0h want 0 0", s_iv, s_rv); end
        vectors++; if (s_led !== 10'h0 || s_ra !== 16'h0) begin miscompares++;
          $display("FAIL mid_reset_pc: got ledr=%0h addr=%0h want 0 0", s_led, s_ra); end
      end
      if (s_iv && first < 0) first = c;
      if (s_hs) begin
        vectors++; if (s_pc !== 16'(n)) begin miscompares++; $display("FAIL mid_seq: got %0h want %0h", s_pc, n); end
        n++;
      end
    end
    vectors++; if (first != 3) begin miscompares++; $display("FAIL mid_first_valid: got %0d want 3", first); end
    vectors++; if (n != 4) begin miscompares++; $display("FAIL mid_count: got %0d want 4", n); end
  endtask

  initial begin
    reset          = 1'b1;
    mem_req_ready  = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_throughput();
    test_backpressure();
    test_mem_stall();
    test_redirect_flush();
    test_wrap_and_clamp();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
